// File: rtl/control.sv
// LC-3b multicycle datapath controller: a Moore FSM that sequences fetch,
// decode and execute for ALU ops, branches, JMP, LEA and word loads/stores.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

endpackage

module control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  lc3b_opcode opcode,
  input  logic       imm_mode,
  input  logic       br_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       storemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] pcmux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic [1:0] mem_byte_enable,
  output lc3b_aluop  aluop,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH1    = 4'd0,
    S_FETCH2    = 4'd1,
    S_FETCH3    = 4'd2,
    S_DECODE    = 4'd3,
    S_ADD       = 4'd4,
    S_AND       = 4'd5,
    S_NOT       = 4'd6,
    S_BR        = 4'd7,
    S_BR_TAKEN  = 4'd8,
    S_JMP       = 4'd9,
    S_LEA       = 4'd10,
    S_CALC_ADDR = 4'd11,
    S_LDR1      = 4'd12,
    S_LDR2      = 4'd13,
    S_STR1      = 4'd14,
    S_STR2      = 4'd15
  } state_e;

  state_e state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: if (mem_resp) state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          op_add:         state_d = S_ADD;
          op_and:         state_d = S_AND;
          op_not:         state_d = S_NOT;
          op_br:          state_d = S_BR;
          op_jmp:         state_d = S_JMP;
          op_lea:         state_d = S_LEA;
          op_ldr, op_str: state_d = S_CALC_ADDR;
          default:        state_d = S_FETCH1;
        endcase
      end
      S_BR:        state_d = br_enable ? S_BR_TAKEN : S_FETCH1;
      S_CALC_ADDR: state_d = (opcode == op_ldr) ? S_LDR1 : S_STR1;
      S_LDR1:      if (mem_resp) state_d = S_LDR2;
      S_STR1:      state_d = S_STR2;
      S_STR2:      if (mem_resp) state_d = S_FETCH1;
      default:     state_d = S_FETCH1;
    endcase
  end

  assign mem_byte_enable = 2'b11;
  assign state_dbg       = state_q;

  // NOTE: every output gets a default before the case, so no path through
  // this block can leave a variable unassigned and infer a latch.
  // Outputs are also held at defaults while rst_n is low, which drops any
  // in-flight memory strobe in the same cycle the reset arrives.
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    storemux_sel   = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    pcmux_sel      = 2'b00;
    alumux_sel     = 2'b00;
    regfilemux_sel = 2'b00;
    aluop          = alu_add;
    if (rst_n) begin
      case (state_q)
        S_FETCH1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        S_FETCH2, S_LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        S_FETCH3: load_ir = 1'b1;
        S_ADD, S_AND: begin
          aluop        = (state_q == S_AND) ? alu_and : alu_add;
          alumux_sel   = imm_mode ? 2'b10 : 2'b00;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_NOT: begin
          aluop        = alu_not;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_BR_TAKEN: begin
          pcmux_sel = 2'b01;
          load_pc   = 1'b1;
        end
        S_JMP: begin
          aluop     = alu_pass;
          pcmux_sel = 2'b10;
          load_pc   = 1'b1;
        end
        S_LEA: begin
          regfilemux_sel = 2'b10;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        S_CALC_ADDR: begin
          alumux_sel = 2'b01;
          load_mar   = 1'b1;
        end
        S_LDR2: begin
          regfilemux_sel = 2'b01;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        S_STR1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
        end
        S_STR2: begin
          storemux_sel = 1'b1;
          mem_write    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: an instruction-level model expands each
// instruction into its expected per-cycle state/control trace for a scoreboard.
module tb_control;
  import lc3b_types::*;

  logic       clk;
  logic       rst_n;
  lc3b_opcode opcode;
  logic       imm_mode, br_enable, mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       storemux_sel, marmux_sel, mdrmux_sel, mem_read, mem_write;
  logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
  lc3b_aluop  aluop;
  logic [3:0] state_dbg;

  control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imm_mode(imm_mode),
    .br_enable(br_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .storemux_sel(storemux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .mem_read(mem_read), .mem_write(mem_write), .pcmux_sel(pcmux_sel),
    .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
    .mem_byte_enable(mem_byte_enable), .aluop(aluop), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic       storemux_sel, marmux_sel, mdrmux_sel, mem_read, mem_write;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
    logic [2:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Control word for a given architectural state, read off the state's
  // description; any out-of-range state means "reset defaults".
  function automatic ctrl_t expect_ctrl(input int st, input bit imm);
    ctrl_t c = '0;
    c.mem_byte_enable = 2'b11;
    c.aluop           = alu_add;
    case (st)
      0:  begin c.marmux_sel = 1; c.load_mar = 1; c.load_pc = 1; end
      1, 12: begin c.mem_read = 1; c.mdrmux_sel = 1; c.load_mdr = 1; end
      2:  c.load_ir = 1;
      4, 5: begin
        c.aluop = (st == 5) ? alu_and : alu_add;
        c.alumux_sel = imm ? 2'b10 : 2'b00;
        c.load_regfile = 1; c.load_cc = 1;
      end
      6:  begin c.aluop = alu_not; c.load_regfile = 1; c.load_cc = 1; end
      8:  begin c.pcmux_sel = 2'b01; c.load_pc = 1; end
      9:  begin c.aluop = alu_pass; c.pcmux_sel = 2'b10; c.load_pc = 1; end
      10: begin c.regfilemux_sel = 2'b10; c.load_regfile = 1; c.load_cc = 1; end
      11: begin c.alumux_sel = 2'b01; c.load_mar = 1; end
      13: begin c.regfilemux_sel = 2'b01; c.load_regfile = 1; c.load_cc = 1; end
      14: begin c.storemux_sel = 1; c.aluop = alu_pass; c.load_mdr = 1; end
      15: begin c.storemux_sel = 1; c.mem_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t sample_ctrl();
    ctrl_t c;
    c.load_pc = load_pc; c.load_ir = load_ir; c.load_regfile = load_regfile;
    c.load_mar = load_mar; c.load_mdr = load_mdr; c.load_cc = load_cc;
    c.storemux_sel = storemux_sel; c.marmux_sel = marmux_sel;
    c.mdrmux_sel = mdrmux_sel; c.mem_read = mem_read; c.mem_write = mem_write;
    c.pcmux_sel = pcmux_sel; c.alumux_sel = alumux_sel;
    c.regfilemux_sel = regfilemux_sel; c.mem_byte_enable = mem_byte_enable;
    c.aluop = aluop;
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
    check({tag, "_ctrl"}, 32'(sample_ctrl()), 32'(expect_ctrl(-1, 1'b0)));
  endtask

  // Monitor: each cycle out of reset, compare the DUT against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("state@%0d", cyc), 32'(state_dbg), 32'(e.st));
        check($sformatf("ctrl@%0d(st%0d)", cyc, e.st), 32'(sample_ctrl()), 32'(e.c));
        cyc++;
      end
    end
  end

  // Expands one instruction into its cycle trace, drives mem_resp along it
  // (random outside wait states, where it must be ignored) and optionally
  // asserts reset mid-cycle at trace index abort_at.
  task automatic run_instr(input logic [3:0] op, input bit imm, input bit br,
                           input int wf, input int wm, input int abort_at);
    int seq[$];
    bit resp[$];
    seq.push_back(0); resp.push_back(1'($urandom));
    for (int i = 0; i <= wf; i++) begin seq.push_back(1); resp.push_back(i == wf); end
    seq.push_back(2); resp.push_back(1'($urandom));
    seq.push_back(3); resp.push_back(1'($urandom));
    case (op)
      4'b0001: begin seq.push_back(4); resp.push_back(1'($urandom)); end
      4'b0101: begin seq.push_back(5); resp.push_back(1'($urandom)); end
      4'b1001: begin seq.push_back(6); resp.push_back(1'($urandom)); end
      4'b0000: begin
        seq.push_back(7); resp.push_back(1'($urandom));
        if (br) begin seq.push_back(8); resp.push_back(1'($urandom)); end
      end
      4'b1100: begin seq.push_back(9);  resp.push_back(1'($urandom)); end
      4'b1110: begin seq.push_back(10); resp.push_back(1'($urandom)); end
      4'b0110: begin
        seq.push_back(11); resp.push_back(1'($urandom));
        for (int i = 0; i <= wm; i++) begin seq.push_back(12); resp.push_back(i == wm); end
        seq.push_back(13); resp.push_back(1'($urandom));
      end
      4'b0111: begin
        seq.push_back(11); resp.push_back(1'($urandom));
        seq.push_back(14); resp.push_back(1'($urandom));
        for (int i = 0; i <= wm; i++) begin seq.push_back(15); resp.push_back(i == wm); end
      end
      default: ;
    endcase
    opcode    = lc3b_opcode'(op);
    imm_mode  = imm;
    br_enable = br;
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_at) begin
        mem_resp = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort_async");
        @(posedge clk); #1;
        check_reset_outputs("abort_held");
        rst_n = 1'b1;
        return;
      end
      sb.push_back('{st: 4'(seq[k]), c: expect_ctrl(seq[k], imm)});
      mem_resp = resp[k];
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = op_br; imm_mode = 0; br_enable = 0; mem_resp = 1;
    #3 check_reset_outputs("por");
    @(posedge clk); #1;
    check_reset_outputs("por_edge");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(4'b0001, 1, 0, 2, 0, -1);   // ADD imm, fetch waits two cycles
    run_instr(4'b0000, 0, 1, 0, 0, -1);   // BR taken
    run_instr(4'b0000, 0, 0, 0, 0, -1);   // BR not taken
    run_instr(4'b0110, 0, 0, 0, 0, -1);   // LDR, immediate response
    run_instr(4'b0111, 0, 0, 0, 4, -1);   // STR, four extra wait cycles
    run_instr(4'b1111, 1, 1, 0, 0, -1);   // TRAP: no architectural write
    run_instr(4'b0110, 0, 0, 0, 3, 6);    // reset mid LDR1
    run_instr(4'b0101, 0, 0, 0, 0, -1);   // fetch after abort
    run_instr(4'b0111, 0, 0, 0, 3, 7);    // reset mid STR2
    run_instr(4'b0001, 0, 0, 1, 0, 2);    // reset mid FETCH2
    run_instr(4'b1100, 0, 0, 0, 0, -1);

    for (int n = 0; n < 80; n++)
      run_instr(4'($urandom_range(15)), 1'($urandom), 1'($urandom),
                $urandom_range(2), $urandom_range(3), -1);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have inputs opcode (lc3b_opcode, 4 bits, IR[15:12]), imm_mode (1 bit, IR[5]), br_enable (1 bit), and mem_resp (1 bit, memory access complete).
REQ-005 SHALL have 1-bit outputs load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc, storemux_sel, marmux_sel, mdrmux_sel, mem_read and mem_write.
REQ-006 SHALL have 2-bit outputs pcmux_sel, alumux_sel, regfilemux_sel and mem_byte_enable.
REQ-007 SHALL have output aluop (lc3b_aluop).
REQ-008 SHALL have output state_dbg, 4 bits, giving the current state encoding.

Function
REQ-009 SHALL be a Moore FSM: outputs decode from state only, and br_enable, imm_mode and mem_resp affect only next state, except alumux_sel in ADD/AND.
REQ-010 SHALL use these state encodings: FETCH1=0, FETCH2=1, FETCH3=2, DECODE=3, ADD=4, AND=5, NOT=6, BR=7, BR_TAKEN=8, JMP=9, LEA=10, CALC_ADDR=11, LDR1=12, LDR2=13, STR1=14, STR2=15.
REQ-011 SHALL use these output defaults in every state unless listed otherwise: all loads 0, all selects 0, aluop=add, mem_read=0, mem_write=0, mem_byte_enable=2'b11 (constant).
REQ-012 FETCH1: marmux_sel=1, load_mar=1, pcmux_sel=00, load_pc=1; next state FETCH2.
REQ-013 FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=1; stay while mem_resp=0, go to FETCH3 when mem_resp=1.
REQ-014 FETCH3: load_ir=1; next state DECODE.
REQ-015 DECODE: outputs at defaults. Next state by opcode: ADD->ADD, AND->AND, NOT->NOT, BR->BR, JMP->JMP, LEA->LEA, LDR/STR->CALC_ADDR; all other opcodes (LDB, LDI, STB, STI, JSR, SHF, TRAP, RTI) ->FETCH1, with no architectural write.
REQ-016 ADD/AND: aluop=add/and, alumux_sel=10 if imm_mode=1 else 00, regfilemux_sel=00, load_regfile=1, load_cc=1; next state FETCH1.
REQ-017 NOT: aluop=not, load_regfile=1, load_cc=1; next state FETCH1.
REQ-018 BR: outputs at defaults; next state BR_TAKEN if br_enable=1, else FETCH1.
REQ-019 BR_TAKEN: pcmux_sel=01, load_pc=1; next state FETCH1.
REQ-020 JMP: aluop=pass, storemux_sel=0, pcmux_sel=10, load_pc=1; next state FETCH1.
REQ-021 LEA: regfilemux_sel=10, load_regfile=1, load_cc=1; next state FETCH1.
REQ-022 CALC_ADDR: storemux_sel=0, alumux_sel=01, aluop=add, marmux_sel=0, load_mar=1; next state LDR1 if opcode=LDR, else STR1.
REQ-023 LDR1: mem_read=1, mdrmux_sel=1, load_mdr=1; wait on mem_resp as in FETCH2, then go to LDR2.
REQ-024 LDR2: regfilemux_sel=01, load_regfile=1, load_cc=1; next state FETCH1.
REQ-025 STR1: storemux_sel=1, aluop=pass, mdrmux_sel=0, load_mdr=1; next state STR2.
REQ-026 STR2: storemux_sel=1, mem_write=1; stay while mem_resp=0, go to FETCH1 when mem_resp=1.
REQ-027 SHALL ignore mem_resp in every state except FETCH2, LDR1 and STR2.
REQ-028 SHALL leave a wait state on the next edge when mem_resp=1 in the first cycle of that state, so the minimum wait-state residency is 1 cycle.
REQ-029 SHALL never assert mem_read and mem_write together.
REQ-030 SHALL make ALU-op instruction latency 5 cycles with zero memory wait: FETCH1, FETCH2, FETCH3, DECODE, execute.

Reset
REQ-031 On rst_n=0, state SHALL go to FETCH1 immediately (asynchronous), without waiting for clk.
REQ-032 While rst_n=0, all outputs SHALL be forced to defaults, including load_pc=0, mem_read=0 and mem_write=0, and state_dbg SHALL be 0.
REQ-033 After rst_n rises, the first rising edge of clk SHALL execute FETCH1.
REQ-034 A reset asserted mid-access in FETCH2, LDR1 or STR2 SHALL drop mem_read/mem_write in the same cycle, and the interrupted instruction SHALL be abandoned.

Verification
REQ-035 Reset then fetch of ADD (opcode=0001, imm_mode=1), mem_resp=1 on the 3rd FETCH2 cycle -> state_dbg sequence 0,1,1,1,2,3,4,0; alumux_sel=10 and load_regfile=1 in state 4.
REQ-036 BR with br_enable=1 -> state_dbg 3,7,8,0 with pcmux_sel=01 and load_pc=1 in state 8; the same with br_enable=0 -> 3,7,0 and no load_pc in state 7.
REQ-037 LDR with mem_resp=1 immediately -> states 3,11,12,13,0; load_mar=1 with alumux_sel=01 in state 11; regfilemux_sel=01 in state 13.
REQ-038 STR with mem_resp held low 4 cycles in STR2 -> mem_write=1 for 5 cycles, mem_read=0 throughout, then state 0.
REQ-039 Opcode TRAP (1111) in DECODE -> next state 0 with no load_regfile, load_pc or load_cc asserted.
REQ-040 rst_n pulsed low mid-cycle during LDR1 -> mem_read=0 and state_dbg=0 before the next clk edge; the next fetch proceeds normally.
